// File: rtl/c1bias_fetch_if.sv
// Signal bundle shared by the conv-1 bias fetcher, the bias ROM read port
// and the accumulator's valid/ready input.
interface c1bias_fetch_if #(
  parameter int PARA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rom_raddr;
  logic [PARA_WIDTH-1:0] rom_dout;
  logic                  bias_valid;
  logic                  bias_ready;
  logic [PARA_WIDTH-1:0] bias_data;
  logic [ADDR_WIDTH-1:0] bias_ch;

  modport master (
    output rom_raddr,
    input  rom_dout,
    output bias_valid,
    input  bias_ready,
    output bias_data,
    output bias_ch
  );

  modport slave (
    input  rom_raddr,
    output rom_dout,
    input  bias_valid,
    output bias_ready,
    input  bias_data,
    input  bias_ch
  );
endinterface

// File: rtl/c1bias_fetch.sv
// Conv-1 bias fetcher: walks the bias ROM once per start, hides its one-cycle
// read latency, and streams {channel, bias} through a 4-deep FIFO.
module c1bias_fetch #(
  parameter int PARA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int BIAS_NUM   = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  c1bias_fetch_if.master bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int FIFO_DEPTH = 4;
  localparam logic [CNT_W-1:0] BIAS_END  = CNT_W'(BIAS_NUM);
  localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(BIAS_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] idx;
  } tag_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] ch;
    logic [PARA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
  logic [ADDR_WIDTH-1:0] rom_raddr_q, rom_raddr_d;
  tag_t                  tag0_q, tag0_d;
  tag_t                  tag1_q, tag1_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_count_q, fifo_count_d;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_ok;
  logic [2:0]            inflight;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  entry_t                head;

  // Reads already issued count against FIFO space, so a push never finds it full.
  assign inflight   = {2'b00, tag0_q.vld} + {2'b00, tag1_q.vld};
  assign issue_ok   = (issue_idx_q < BIAS_END) && ((fifo_count_q + inflight) < 3'd4);
  assign head_valid = (fifo_count_q != 3'd0);
  assign pop        = head_valid && bus.bias_ready;
  assign push       = tag1_q.vld;
  assign head       = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    acc_cnt_d   = acc_cnt_q;
    issue       = 1'b0;
    issue_addr  = '0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Address 0 goes out on the start edge itself to get a 3-cycle first word.
        if (start) begin
          state_d     = RUN;
          issue       = 1'b1;
          issue_addr  = '0;
          issue_idx_d = CNT_W'(1);
          acc_cnt_d   = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue_ok) begin
          issue       = 1'b1;
          issue_addr  = issue_idx_q[ADDR_WIDTH-1:0];
          issue_idx_d = issue_idx_q + CNT_W'(1);
        end
        if (pop) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == BIAS_LAST) state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_raddr_d = issue ? issue_addr : rom_raddr_q;
    tag0_d      = '{vld: issue, idx: issue_addr};
    tag1_d      = tag0_q;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{ch: tag1_q.idx, data: bus.rom_dout};
    wr_ptr_d     = wr_ptr_q + {1'b0, push};
    rd_ptr_d     = rd_ptr_q + {1'b0, pop};
    fifo_count_d = fifo_count_q + {2'b00, push} - {2'b00, pop};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_idx_q  <= '0;
      acc_cnt_q    <= '0;
      rom_raddr_q  <= '0;
      tag0_q       <= '0;
      tag1_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      issue_idx_q  <= issue_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      rom_raddr_q  <= rom_raddr_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the head is masked by valid,
  // so stale entries are never visible and the array stays plain registers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.rom_raddr  = rom_raddr_q;
  assign bus.bias_valid = head_valid;
  assign bus.bias_data  = head_valid ? head.data : '0;
  assign bus.bias_ch    = head_valid ? head.ch : '0;
endmodule

// File: tb/tb_c1bias_fetch.sv
// Directed bench for c1bias_fetch: cycle tables for the two basic runs, then
// restart/reset/random-ready sequences and BIAS_NUM=1 / BIAS_NUM=32 instances.
module tb_c1bias_fetch;
  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  c1bias_fetch_if #(.PARA_WIDTH(16), .ADDR_WIDTH(5)) bus0 ();
  c1bias_fetch_if #(.PARA_WIDTH(16), .ADDR_WIDTH(5)) bus1 ();
  c1bias_fetch_if #(.PARA_WIDTH(16), .ADDR_WIDTH(5)) bus2 ();

  c1bias_fetch #(.PARA_WIDTH(16), .ADDR_WIDTH(5), .BIAS_NUM(6)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .bus(bus0));
  c1bias_fetch #(.PARA_WIDTH(16), .ADDR_WIDTH(5), .BIAS_NUM(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1));
  c1bias_fetch #(.PARA_WIDTH(16), .ADDR_WIDTH(5), .BIAS_NUM(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2));

  always #5 clk = ~clk;

  // Bias ROM model: registered read, word i holds 0x0011*(i+1).
  logic [15:0] rom [32];
  initial for (int i = 0; i < 32; i++) rom[i] = 16'(16'h0011 * (i + 1));

  always @(posedge clk) begin
    bus0.rom_dout <= rom[bus0.rom_raddr];
    bus1.rom_dout <= rom[bus1.rom_raddr];
    bus2.rom_dout <= rom[bus2.rom_raddr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO overflow flag and hold-while-stalled monitor on the main instance.
  int ovf_err  = 0;
  int stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [4:0]  prev_ch;

  always @(posedge clk) begin
    if (!rst) assert (!(dut0.push && dut0.fifo_count_q == 3'd4)) else ovf_err++;
  end

  always @(negedge clk) begin
    if (!rst && prev_stall &&
        (!bus0.bias_valid || bus0.bias_data !== prev_data || bus0.bias_ch !== prev_ch))
      stab_err++;
    prev_stall = !rst && bus0.bias_valid && !bus0.bias_ready;
    prev_data  = bus0.bias_data;
    prev_ch    = bus0.bias_ch;
  end

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [4:0]  exp_ch;
    logic [4:0]  exp_raddr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [31];

  function automatic vec_t mk(input logic s, input logic r, input logic v, input logic [15:0] d,
                              input logic [4:0] ch, input logic [4:0] ra, input logic b,
                              input logic dn);
    vec_t x;
    x.start = s; x.ready = r; x.exp_valid = v; x.exp_data = d;
    x.exp_ch = ch; x.exp_raddr = ra; x.exp_busy = b; x.exp_done = dn;
    return x;
  endfunction

  // Each entry is one cycle: inputs driven just after the edge, outputs checked then.
  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk); #1;
      start0 = vecs[i].start;
      bus0.bias_ready = vecs[i].ready;
      check($sformatf("vec%0d valid", i), bus0.bias_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d data", i),  bus0.bias_data,  vecs[i].exp_data);
      check($sformatf("vec%0d ch", i),    bus0.bias_ch,    vecs[i].exp_ch);
      check($sformatf("vec%0d raddr", i), bus0.rom_raddr,  vecs[i].exp_raddr);
      check($sformatf("vec%0d busy", i),  busy0,           vecs[i].exp_busy);
      check($sformatf("vec%0d done", i),  done0,           vecs[i].exp_done);
    end
  endtask

  // One full run on dut0; start_mask bit k pulses start in cycle k of the run.
  task automatic run_seq(input string tag, input logic [31:0] start_mask, input bit rnd);
    int got   = 0;
    int dones = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      start0 = (cyc < 32) ? start_mask[cyc] : 1'b0;
      bus0.bias_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 0) begin
        check({tag, " idle busy"}, busy0, 1'b0);
        check({tag, " idle done"}, done0, 1'b0);
      end
      if (done0) begin
        dones++;
        break;
      end
      if (bus0.bias_valid && bus0.bias_ready) begin
        check({tag, " ch"},   bus0.bias_ch,   got);
        check({tag, " data"}, bus0.bias_data, 16'(16'h0011 * (got + 1)));
        got++;
      end
    end
    check({tag, " words"}, got, 6);
    check({tag, " done pulses"}, dones, 1);
  endtask

  initial begin
    // Basic run, bias_ready tied high.
    vecs[0]  = mk(1, 1, 0, 16'h0000, 5'd0, 5'd0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 16'h0000, 5'd0, 5'd0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 16'h0000, 5'd0, 5'd1, 1, 0);
    vecs[3]  = mk(0, 1, 1, 16'h0011, 5'd0, 5'd2, 1, 0);
    vecs[4]  = mk(0, 1, 1, 16'h0022, 5'd1, 5'd3, 1, 0);
    vecs[5]  = mk(0, 1, 1, 16'h0033, 5'd2, 5'd4, 1, 0);
    vecs[6]  = mk(0, 1, 1, 16'h0044, 5'd3, 5'd5, 1, 0);
    vecs[7]  = mk(0, 1, 1, 16'h0055, 5'd4, 5'd5, 1, 0);
    vecs[8]  = mk(0, 1, 1, 16'h0066, 5'd5, 5'd5, 1, 0);
    vecs[9]  = mk(0, 1, 0, 16'h0000, 5'd0, 5'd5, 0, 1);
    vecs[10] = mk(0, 1, 0, 16'h0000, 5'd0, 5'd5, 0, 0);
    // bias_ready low until cycle 12: issue stalls at address 3, FIFO fills to 4.
    vecs[11] = mk(1, 0, 0, 16'h0000, 5'd0, 5'd5, 0, 0);
    vecs[12] = mk(0, 0, 0, 16'h0000, 5'd0, 5'd0, 1, 0);
    vecs[13] = mk(0, 0, 0, 16'h0000, 5'd0, 5'd1, 1, 0);
    vecs[14] = mk(0, 0, 1, 16'h0011, 5'd0, 5'd2, 1, 0);
    for (int c = 4; c <= 11; c++) vecs[11 + c] = mk(0, 0, 1, 16'h0011, 5'd0, 5'd3, 1, 0);
    vecs[23] = mk(0, 1, 1, 16'h0011, 5'd0, 5'd3, 1, 0);
    vecs[24] = mk(0, 1, 1, 16'h0022, 5'd1, 5'd3, 1, 0);
    vecs[25] = mk(0, 1, 1, 16'h0033, 5'd2, 5'd4, 1, 0);
    vecs[26] = mk(0, 1, 1, 16'h0044, 5'd3, 5'd5, 1, 0);
    vecs[27] = mk(0, 1, 1, 16'h0055, 5'd4, 5'd5, 1, 0);
    vecs[28] = mk(0, 1, 1, 16'h0066, 5'd5, 5'd5, 1, 0);
    vecs[29] = mk(0, 1, 0, 16'h0000, 5'd0, 5'd5, 0, 1);
    vecs[30] = mk(0, 1, 0, 16'h0000, 5'd0, 5'd5, 0, 0);

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bus0.bias_ready = 1'b0; bus1.bias_ready = 1'b1; bus2.bias_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", bus0.bias_valid, 1'b0);
    check("reset data",  bus0.bias_data,  16'h0000);
    check("reset ch",    bus0.bias_ch,    5'd0);
    check("reset raddr", bus0.rom_raddr,  5'd0);
    check("reset busy",  busy0,           1'b0);
    check("reset done",  done0,           1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_vecs(0, 10);
    run_vecs(11, 30);

    // Restart pulses mid-run, start in the FINISH cycle, then start right after done.
    run_seq("restart", 32'h0000_0025, 1'b0);
    run_seq("fin_start", 32'h0000_0201, 1'b0);
    run_seq("back2back", 32'h0000_0001, 1'b0);

    for (int r = 0; r < 20; r++) run_seq($sformatf("rnd%0d", r), 32'h0000_0001, 1'b1);

    // Reset in cycle 4 with words buffered, then a fresh full run.
    begin
      int stray = 0;
      @(posedge clk); #1;
      start0 = 1'b1;
      bus0.bias_ready = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        start0 = 1'b0;
      end
      @(posedge clk); #1;
      check("pre-rst valid", bus0.bias_valid, 1'b1);
      rst = 1'b1;
      #1;
      check("mid-rst valid", bus0.bias_valid, 1'b0);
      check("mid-rst data",  bus0.bias_data,  16'h0000);
      check("mid-rst ch",    bus0.bias_ch,    5'd0);
      check("mid-rst raddr", bus0.rom_raddr,  5'd0);
      check("mid-rst busy",  busy0,           1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus0.bias_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (bus0.bias_valid || busy0) stray++;
      end
      check("post-rst stray", stray, 0);
      run_seq("after_rst", 32'h0000_0001, 1'b0);
    end

    // BIAS_NUM=1: single word in cycle 3, done in cycle 4.
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      start1 = (c == 0);
      check($sformatf("n1 c%0d valid", c), bus1.bias_valid, c == 3);
      check($sformatf("n1 c%0d busy", c),  busy1, (c >= 1) && (c <= 3));
      check($sformatf("n1 c%0d done", c),  done1, c == 4);
      if (c == 3) begin
        check("n1 data", bus1.bias_data, 16'h0011);
        check("n1 ch",   bus1.bias_ch,   5'd0);
      end
    end

    // BIAS_NUM=32: full address range, done in cycle 35, no address wrap.
    begin
      int got      = 0;
      int done_cyc = -1;
      for (int c = 0; c <= 40; c++) begin
        @(posedge clk); #1;
        start2 = (c == 0);
        if (done2) done_cyc = c;
        if (bus2.bias_valid) begin
          check("n32 ch",   bus2.bias_ch,   got);
          check("n32 data", bus2.bias_data, 16'(16'h0011 * (got + 1)));
          got++;
        end
      end
      check("n32 words",    got, 32);
      check("n32 done cyc", done_cyc, 35);
      check("n32 raddr",    bus2.rom_raddr, 5'd31);
      check("n32 busy",     busy2, 1'b0);
    end

    check("fifo overflow", ovf_err, 0);
    check("stall hold",    stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
